byte2planar_vram: RTL and testbench
===================================

BYTE2PLANAR_VRAM -- requirements
Module: byte2planar_vram

Interface
REQ-001 Parameter NCH, default 3: colour planes per pixel; the legal range is 1..8.
REQ-002 Parameter DW, default 8: byte and plane data width.
REQ-003 Parameter AW, default 17: VRAM address width.
REQ-004 Parameter FRAME_PIX, default 76800: pixels per frame; the legal range is 1..2^AW.
REQ-005 Parameter AUTO_WRAP, default 0: 1 = restart at address 0 after the last pixel; 0 = return to IDLE and wait for the next sof.
REQ-006 clk  input  1  write clock (Ethernet byte clock); the only clock in the block.
REQ-007 xrst  input  1  asynchronous active-low reset.
REQ-008 din  input  DW  incoming byte.
REQ-009 den  input  1  din valid this cycle.
REQ-010 sof  input  1  start of frame; qualified by den; marks din as plane 0 of pixel 0.
REQ-011 waddr  output  AW  VRAM port-A address, shared by all planes.
REQ-012 wdata  output  DW  VRAM port-A write data, shared by all planes.
REQ-013 wea  output  NCH  per-plane write enable; one-hot or zero.
REQ-014 ch  output  3  plane index of the next byte to be accepted.
REQ-015 frame_done  output  1  one-cycle pulse coincident with the write of the last plane of pixel FRAME_PIX-1.
REQ-016 sync_err  output  1  one-cycle pulse when sof is accepted while ch!=0 or pix!=0 in RECV.
REQ-017 drop_cnt  output  16  saturating count of bytes discarded in IDLE.

Function
REQ-018 The block SHALL use two states: IDLE and RECV.
REQ-019 IDLE: den=1 and sof=1 SHALL write din to plane 0 at address 0, set ch=1 (ch=0 and pix=1 if NCH=1), and enter RECV.
REQ-020 IDLE: den=1 and sof=0 SHALL write nothing and increment drop_cnt, saturating at 16'hFFFF.
REQ-021 RECV: den=1 and sof=0 SHALL write din to plane ch at address pix, then advance ch.
REQ-022 RECV plane advance: ch SHALL increment; when ch==NCH-1, ch SHALL go to 0 and pix SHALL increment.
REQ-023 RECV end of frame: when ch==NCH-1 and pix==FRAME_PIX-1, the block SHALL pulse frame_done with that write.
REQ-024 After end of frame with AUTO_WRAP=0: the block SHALL set pix=0 and ch=0 and enter IDLE.
REQ-025 After end of frame with AUTO_WRAP=1: the block SHALL set pix=0 and ch=0 and stay in RECV.
REQ-026 RECV: den=1 and sof=1 SHALL restart the frame: write din to plane 0 at address 0, set ch=1, set pix=0.
REQ-027 The restart in REQ-026 SHALL pulse sync_err in the same cycle as that write if ch!=0 or pix!=0 before the byte.
REQ-028 When den=0, state, ch and pix SHALL hold, wea SHALL be 0, and sof SHALL be ignored.
REQ-029 Latency: waddr, wdata and wea SHALL be registered and valid exactly one clk after the accepting den cycle.
REQ-030 frame_done and sync_err SHALL be aligned with the wea cycle of the byte that causes them.
REQ-031 Throughput: the block SHALL accept one byte per clk with no back-pressure and never stall.
REQ-032 wdata SHALL be registered from din on every accepted byte; waddr SHALL hold between writes.
REQ-033 pix SHALL never reach FRAME_PIX; the address SHALL never exceed FRAME_PIX-1.
REQ-034 For NCH=1, every accepted byte SHALL advance pix.

Reset
REQ-035 xrst=0 SHALL asynchronously force: state IDLE, ch=0, pix=0, waddr=0, wdata=0, wea=0, frame_done=0, sync_err=0, drop_cnt=0.
REQ-036 A reset asserted mid-frame SHALL discard the partial frame; after xrst deasserts, bytes SHALL be dropped until the next sof.
REQ-037 Reset release SHALL be synchronised by the instantiating top level; the block SHALL tolerate den=1 on the first clk after release.

Verification (NCH=3, FRAME_PIX=4, DW=8 unless stated)
REQ-038 Scenario 1: sof with byte A0, then 11 contiguous bytes A1..A11 -> the writes SHALL be as below, plus a single frame_done with the A11 write and a return to IDLE.
- wea=001 at waddr 0 with A0, wea=010 at waddr 0 with A1, wea=100 at waddr 0 with A2.
- The pattern repeats through waddr 3.
REQ-039 Scenario 2: five bytes without sof after reset -> wea stays 0 and drop_cnt=5; a following sof byte SHALL be written to plane 0 at address 0.
REQ-040 Scenario 3: AUTO_WRAP=1, 24 bytes, sof on the first byte only -> frame_done SHALL pulse on bytes 12 and 24, and byte 13 SHALL be written to plane 0 at address 0.
REQ-041 Scenario 4: sof, then 4 more bytes, then sof on the 6th byte -> sync_err SHALL pulse once with the 6th write, which goes to plane 0 at address 0, and the next byte SHALL go to plane 1 at address 0.
REQ-042 Scenario 5: den toggled 1/0 each cycle over a full frame -> the writes SHALL be identical to scenario 1, with wea=0 in every den=0 gap.
REQ-043 Scenario 6: xrst pulsed low after 7 bytes -> all outputs SHALL be 0 immediately, and the next frame SHALL need sof and start at plane 0, address 0.

Source files
------------

// File: rtl/byte2planar_vram.sv
// byte2planar_vram: demultiplexes a byte stream into NCH colour planes of a planar VRAM.
// Bytes arrive plane-interleaved (plane 0, 1, ..., NCH-1 of pixel 0, then pixel 1, ...).
// Each accepted byte becomes one registered write on the shared VRAM port A.
//
// Ports:
//   clk        write clock, the only clock in the block
//   xrst       asynchronous active-low reset
//   din        incoming byte
//   den        din valid this cycle
//   sof        start of frame, qualified by den; din is plane 0 of pixel 0
//   waddr      VRAM address, shared by all planes (holds between writes)
//   wdata      VRAM write data, shared by all planes
//   wea        per-plane write enable, one-hot or zero
//   ch         plane index of the next byte to be accepted
//   frame_done pulse with the write of the last plane of the last pixel
//   sync_err   pulse when a sof restarts a frame that was already in progress
//   drop_cnt   saturating count of bytes discarded while idle
module byte2planar_vram #(
   parameter int unsigned NCH       = 3,
   parameter int unsigned DW        = 8,
   parameter int unsigned AW        = 17,
   parameter int unsigned FRAME_PIX = 76800,
   parameter bit          AUTO_WRAP = 1'b0
) (
   input  logic          clk,
   input  logic          xrst,
   input  logic [DW-1:0] din,
   input  logic          den,
   input  logic          sof,
   output logic [AW-1:0] waddr,
   output logic [DW-1:0] wdata,
   output logic [NCH-1:0] wea,
   output logic [2:0]    ch,
   output logic          frame_done,
   output logic          sync_err,
   output logic [15:0]   drop_cnt
);

   localparam logic [2:0]    LastCh  = 3'(NCH - 1);
   localparam logic [AW-1:0] LastPix = AW'(FRAME_PIX - 1);

   typedef enum logic [0:0] {StIdle, StRecv} state_e;

   state_e        state_q, state_d;
   logic [2:0]    ch_q, ch_d;
   logic [AW-1:0] pix_q, pix_d;

   // Position of the byte being written this cycle; a sof forces pixel 0, plane 0.
   logic          wr_en;
   logic [2:0]    wr_ch;
   logic [AW-1:0] wr_pix;
   logic          last_plane;
   logic          last_pix;

   logic [AW-1:0]  waddr_q, waddr_d;
   logic [DW-1:0]  wdata_q, wdata_d;
   logic [NCH-1:0] wea_q, wea_d;
   logic           frame_done_q, frame_done_d;
   logic           sync_err_q, sync_err_d;
   logic [15:0]    drop_cnt_q, drop_cnt_d;

   // State register
   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         state_q <= StIdle;
         ch_q    <= '0;
         pix_q   <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
         pix_q   <= pix_d;
      end
   end

   // Next-state logic
   always_comb begin
      wr_en      = den && (sof || (state_q == StRecv));
      wr_ch      = sof ? 3'd0 : ch_q;
      wr_pix     = sof ? '0 : pix_q;
      last_plane = (wr_ch == LastCh);
      last_pix   = last_plane && (wr_pix == LastPix);
      state_d    = state_q;
      ch_d       = ch_q;
      pix_d      = pix_q;
      if (wr_en) begin
         state_d = StRecv;
         if (last_pix) begin
            ch_d  = 3'd0;
            pix_d = '0;
            if (!AUTO_WRAP) begin
               state_d = StIdle;
            end
         end else if (last_plane) begin
            ch_d  = 3'd0;
            pix_d = wr_pix + AW'(1);
         end else begin
            ch_d  = wr_ch + 3'd1;
            pix_d = wr_pix;
         end
      end
   end

   // Output logic (next values of the registered write port and status)
   always_comb begin
      wea_d        = '0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      drop_cnt_d   = drop_cnt_q;
      if (wr_en) begin
         wea_d        = NCH'(1) << wr_ch;
         waddr_d      = wr_pix;
         wdata_d      = din;
         frame_done_d = last_pix;
         // Restart only counts as an error if a frame was partly received.
         sync_err_d   = (state_q == StRecv) && sof && ((ch_q != 3'd0) || (pix_q != '0));
      end else if (den && (state_q == StIdle) && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge xrst) begin
      if (!xrst) begin
         waddr_q      <= '0;
         wdata_q      <= '0;
         wea_q        <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
         drop_cnt_q   <= '0;
      end else begin
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         wea_q        <= wea_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign waddr      = waddr_q;
   assign wdata      = wdata_q;
   assign wea        = wea_q;
   assign ch         = ch_q;
   assign frame_done = frame_done_q;
   assign sync_err   = sync_err_q;
   assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_byte2planar_vram.sv
// Bench for byte2planar_vram: NCH=3, FRAME_PIX=4, DW=8. Two instances share clock and
// reset: u_dut0 with AUTO_WRAP=0 and u_dut1 with AUTO_WRAP=1. Each has its own stimulus
// and an expected-write queue that a negedge monitor drains.
module tb_byte2planar_vram;

   logic clk  = 1'b0;
   logic xrst = 1'b0;
   always #5 clk = ~clk;

   logic [7:0]  din0, din1;
   logic        den0, sof0, den1, sof1;
   logic [16:0] waddr0, waddr1;
   logic [7:0]  wdata0, wdata1;
   logic [2:0]  wea0, wea1;
   logic [2:0]  ch0, ch1;
   logic        fd0, fd1, se0, se1;
   logic [15:0] drop0, drop1;

   byte2planar_vram #(
      .NCH(3), .DW(8), .AW(17), .FRAME_PIX(4), .AUTO_WRAP(1'b0)
   ) u_dut0 (
      .clk(clk), .xrst(xrst), .din(din0), .den(den0), .sof(sof0),
      .waddr(waddr0), .wdata(wdata0), .wea(wea0), .ch(ch0),
      .frame_done(fd0), .sync_err(se0), .drop_cnt(drop0)
   );

   byte2planar_vram #(
      .NCH(3), .DW(8), .AW(17), .FRAME_PIX(4), .AUTO_WRAP(1'b1)
   ) u_dut1 (
      .clk(clk), .xrst(xrst), .din(din1), .den(den1), .sof(sof1),
      .waddr(waddr1), .wdata(wdata1), .wea(wea1), .ch(ch1),
      .frame_done(fd1), .sync_err(se1), .drop_cnt(drop1)
   );

   int nchk  = 0;
   int nfail = 0;

   // Expected write: {addr[16:0], data[7:0], wea[2:0], frame_done, sync_err}
   logic [29:0] q0[$];
   logic [29:0] q1[$];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic logic [29:0] mk(input int addr, input logic [7:0] d, input int plane,
                                      input logic fd, input logic se);
      logic [2:0] one;
      one = 3'b001;
      return {17'(addr), d, 3'(one << plane), fd, se};
   endfunction

   task automatic send(input bit which, input logic [7:0] d, input logic s, input bit wr,
                       input int addr, input int plane, input logic fd, input logic se);
      @(posedge clk);
      #1;
      den0 = 1'b0; sof0 = 1'b0; den1 = 1'b0; sof1 = 1'b0;
      if (!which) begin
         din0 = d; sof0 = s; den0 = 1'b1;
         if (wr) q0.push_back(mk(addr, d, plane, fd, se));
      end else begin
         din1 = d; sof1 = s; den1 = 1'b1;
         if (wr) q1.push_back(mk(addr, d, plane, fd, se));
      end
   endtask

   // Idle cycle; sof may be raised to show it is ignored without den.
   task automatic gap(input logic s);
      @(posedge clk);
      #1;
      den0 = 1'b0; sof0 = s; den1 = 1'b0; sof1 = s;
   endtask

   always @(negedge clk) begin
      if (xrst && ((wea0 != 3'b000) || fd0 || se0)) begin
         if (q0.size() == 0) begin
            nchk++; nfail++;
            $display("FAIL dut0_unexpected_write: got addr %0d wea %b fd %b se %b, expected none",
                     waddr0, wea0, fd0, se0);
         end else begin
            check("dut0_write", 64'({waddr0, wdata0, wea0, fd0, se0}), 64'(q0.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (xrst && ((wea1 != 3'b000) || fd1 || se1)) begin
         if (q1.size() == 0) begin
            nchk++; nfail++;
            $display("FAIL dut1_unexpected_write: got addr %0d wea %b fd %b se %b, expected none",
                     waddr1, wea1, fd1, se1);
         end else begin
            check("dut1_write", 64'({waddr1, wdata1, wea1, fd1, se1}), 64'(q1.pop_front()));
         end
      end
   end

   initial begin
      din0 = '0; den0 = 1'b0; sof0 = 1'b0;
      din1 = '0; den1 = 1'b0; sof1 = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      check("reset_dut0", 64'({waddr0, wdata0, wea0, ch0, fd0, se0, drop0}), 64'd0);
      check("reset_dut1", 64'({waddr1, wdata1, wea1, ch1, fd1, se1, drop1}), 64'd0);
      @(negedge clk);
      xrst = 1'b1;

      // Bytes without sof are dropped and counted.
      for (int i = 0; i < 5; i++) send(1'b0, 8'h50 + 8'(i), 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      gap(1'b0);
      check("drop_cnt_5", 64'(drop0), 64'd5);

      // Full contiguous frame starting with sof.
      for (int i = 0; i < 12; i++)
         send(1'b0, 8'hA0 + 8'(i), i == 0, 1'b1, i / 3, i % 3, i == 11, 1'b0);
      gap(1'b0);
      check("ch_after_frame", 64'(ch0), 64'd0);
      send(1'b0, 8'hEE, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
      gap(1'b0);
      check("idle_after_frame", 64'(drop0), 64'd6);

      // den toggling with sof raised in the gaps.
      for (int i = 0; i < 12; i++) begin
         send(1'b0, 8'hB0 + 8'(i), i == 0, 1'b1, i / 3, i % 3, i == 11, 1'b0);
         gap(1'b1);
      end
      gap(1'b0);
      check("drop_cnt_after_toggle", 64'(drop0), 64'd6);

      // Mid-frame sof restarts with sync_err.
      send(1'b0, 8'hC0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
      send(1'b0, 8'hC1, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
      send(1'b0, 8'hC2, 1'b0, 1'b1, 0, 2, 1'b0, 1'b0);
      send(1'b0, 8'hC3, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
      send(1'b0, 8'hC4, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0);
      send(1'b0, 8'hC5, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1);
      send(1'b0, 8'hC6, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
      gap(1'b0);
      check("ch_after_restart", 64'(ch0), 64'd2);

      // Auto-wrap instance: two frames from a single sof.
      for (int i = 1; i <= 24; i++)
         send(1'b1, 8'h10 + 8'(i), i == 1, 1'b1, ((i - 1) / 3) % 4, (i - 1) % 3,
              (i == 12) || (i == 24), 1'b0);
      gap(1'b0);
      check("dut1_ch_after_wrap", 64'(ch1), 64'd0);
      check("dut1_drop_cnt", 64'(drop1), 64'd0);

      // Seven bytes (sof restarts the open frame), then reset mid-frame.
      send(1'b0, 8'hD0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b1);
      send(1'b0, 8'hD1, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
      send(1'b0, 8'hD2, 1'b0, 1'b1, 0, 2, 1'b0, 1'b0);
      send(1'b0, 8'hD3, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0);
      send(1'b0, 8'hD4, 1'b0, 1'b1, 1, 1, 1'b0, 1'b0);
      send(1'b0, 8'hD5, 1'b0, 1'b1, 1, 2, 1'b0, 1'b0);
      send(1'b0, 8'hD6, 1'b0, 1'b1, 2, 0, 1'b0, 1'b0);
      gap(1'b0);
      @(negedge clk);
      #1;
      check("pre_reset_ch", 64'(ch0), 64'd1);
      check("pre_reset_waddr", 64'(waddr0), 64'd2);
      xrst = 1'b0;
      #1;
      check("async_reset_dut0", 64'({waddr0, wdata0, wea0, ch0, fd0, se0, drop0}), 64'd0);
      check("async_reset_dut1", 64'({waddr1, wdata1, wea1, ch1, fd1, se1, drop1}), 64'd0);
      @(negedge clk);
      xrst = 1'b1;
      din0 = 8'hF0; sof0 = 1'b0; den0 = 1'b1;   // valid on the first clk after release
      send(1'b0, 8'hE0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0);
      send(1'b0, 8'hE1, 1'b0, 1'b1, 0, 1, 1'b0, 1'b0);
      gap(1'b0);
      gap(1'b0);
      check("drop_after_reset", 64'(drop0), 64'd1);
      check("ch_after_reset_frame", 64'(ch0), 64'd2);

      repeat (3) gap(1'b0);
      check("dut0_queue_drained", 64'(q0.size()), 64'd0);
      check("dut1_queue_drained", 64'(q1.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
